// File: rtl/id_pkg.sv
// Shared definitions for the decode/issue stage: branch-kind encodings and
// parameter defaults used by the stage and its register file.
package id_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned AW_DEF      = 5;
    localparam int unsigned NUM_FWD_DEF = 3;
    localparam int unsigned CTRL_W_DEF  = 16;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JIRL = 2'd3
    } br_kind_e;

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port. Writes to x0 are dropped; x0 reads are forced to zero by the user.
module id_regfile
    import id_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned AW     = AW_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: holds one instruction, resolves its operands through the
// forwarding network, stalls on pending producers and resolves branches.
module id_issue_stage
    import id_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned NUM_FWD = NUM_FWD_DEF,
    parameter int unsigned CTRL_W  = CTRL_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [DATA_W-1:0]         in_pred_pc,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [AW-1:0]             in_rs1,
    input  logic [AW-1:0]             in_rs2,
    input  logic [AW-1:0]             in_rd,
    input  logic                      in_use_rs1,
    input  logic                      in_use_rs2,
    input  logic [1:0]                in_br_kind,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_src1,
    output logic [DATA_W-1:0]         out_src2,
    output logic [DATA_W-1:0]         out_pc,
    output logic [DATA_W-1:0]         out_imm,
    output logic [AW-1:0]             out_rd,
    output logic [CTRL_W-1:0]         out_ctrl,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*AW-1:0]     fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      wb_en,
    input  logic [AW-1:0]             wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      redirect_valid,
    output logic [DATA_W-1:0]         redirect_pc,
    output logic [31:0]               stall_cnt
);

    logic              v_q;
    logic [DATA_W-1:0] pc_q, pred_pc_q, imm_q;
    logic [AW-1:0]     rs1_q, rs2_q, rd_q;
    logic              use_rs1_q, use_rs2_q;
    br_kind_e          br_kind_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic              hit1, hit2, pend1, pend2;
    logic [DATA_W-1:0] fdata1, fdata2;
    logic [DATA_W-1:0] src1, src2, next_pc;
    logic              go, fire, accept, taken, redirect;

    id_regfile #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_regfile (
        .clk    (clk),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_q),
        .raddr2 (rs2_q),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // Scan from the oldest source down so the youngest matching source wins.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        pend1  = 1'b0;
        pend2  = 1'b0;
        fdata1 = '0;
        fdata2 = '0;
        for (int unsigned i = NUM_FWD; i > 0; i--) begin
            if (fwd_valid[i-1] && (fwd_addr[(i-1)*AW +: AW] == rs1_q)) begin
                hit1   = 1'b1;
                pend1  = fwd_pending[i-1];
                fdata1 = fwd_data[(i-1)*DATA_W +: DATA_W];
            end
            if (fwd_valid[i-1] && (fwd_addr[(i-1)*AW +: AW] == rs2_q)) begin
                hit2   = 1'b1;
                pend2  = fwd_pending[i-1];
                fdata2 = fwd_data[(i-1)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        if (rs1_q == '0)                       src1 = '0;
        else if (hit1)                         src1 = fdata1;
        else if (wb_en && (wb_addr == rs1_q))  src1 = wb_data;
        else                                   src1 = rf_rd1;

        if (rs2_q == '0)                       src2 = '0;
        else if (hit2)                         src2 = fdata2;
        else if (wb_en && (wb_addr == rs2_q))  src2 = wb_data;
        else                                   src2 = rf_rd2;
    end

    assign go = !(use_rs1_q && (rs1_q != '0) && hit1 && pend1) &&
                !(use_rs2_q && (rs2_q != '0) && hit2 && pend2);

    always_comb begin
        taken = ((br_kind_q == BR_BEQ) && (src1 == src2)) ||
                ((br_kind_q == BR_BNE) && (src1 != src2));
        if (br_kind_q == BR_JIRL) next_pc = src1 + imm_q;
        else if (taken)           next_pc = pc_q + imm_q;
        else                      next_pc = pc_q + DATA_W'(4);
    end

    assign out_valid      = v_q && go;
    assign in_ready       = !v_q || (go && out_ready);
    assign fire           = out_valid && out_ready;
    assign accept         = in_valid && in_ready;
    assign redirect       = fire && (br_kind_q != BR_NONE) && (next_pc != pred_pc_q);
    assign redirect_valid = redirect;
    assign redirect_pc    = next_pc;

    assign stall_cnt_d = (v_q && !go && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= 1'b0;
            pc_q        <= '0;
            pred_pc_q   <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            use_rs1_q   <= 1'b0;
            use_rs2_q   <= 1'b0;
            br_kind_q   <= BR_NONE;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            // A redirect squashes whatever was accepted alongside it.
            if (redirect) begin
                v_q <= 1'b0;
            end else if (accept) begin
                v_q       <= 1'b1;
                pc_q      <= in_pc;
                pred_pc_q <= in_pred_pc;
                imm_q     <= in_imm;
                rs1_q     <= in_rs1;
                rs2_q     <= in_rs2;
                rd_q      <= in_rd;
                use_rs1_q <= in_use_rs1;
                use_rs2_q <= in_use_rs2;
                br_kind_q <= br_kind_e'(in_br_kind);
                ctrl_q    <= in_ctrl;
            end else if (fire) begin
                v_q <= 1'b0;
            end
        end
    end

    assign out_src1  = src1;
    assign out_src2  = src2;
    assign out_pc    = pc_q;
    assign out_imm   = imm_q;
    assign out_rd    = rd_q;
    assign out_ctrl  = ctrl_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed-vector bench for id_issue_stage: forwarding priority, load-use
// stall, write-back bypass, branch redirect and reset-during-stall behaviour.
module tb_id_issue_stage;
    import id_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned NUM_FWD = 3;
    localparam int unsigned CTRL_W  = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      in_valid, in_ready;
    logic [DATA_W-1:0]         in_pc, in_pred_pc, in_imm;
    logic [AW-1:0]             in_rs1, in_rs2, in_rd;
    logic                      in_use_rs1, in_use_rs2;
    logic [1:0]                in_br_kind;
    logic [CTRL_W-1:0]         in_ctrl;
    logic                      out_valid, out_ready;
    logic [DATA_W-1:0]         out_src1, out_src2, out_pc, out_imm;
    logic [AW-1:0]             out_rd;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [NUM_FWD-1:0]        fwd_valid, fwd_pending;
    logic [NUM_FWD*AW-1:0]     fwd_addr;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    logic                      wb_en;
    logic [AW-1:0]             wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic                      redirect_valid;
    logic [DATA_W-1:0]         redirect_pc;
    logic [31:0]               stall_cnt;

    id_issue_stage #(
        .DATA_W  (DATA_W),
        .AW      (AW),
        .NUM_FWD (NUM_FWD),
        .CTRL_W  (CTRL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_pred_pc     (in_pred_pc),
        .in_imm         (in_imm),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_rd          (in_rd),
        .in_use_rs1     (in_use_rs1),
        .in_use_rs2     (in_use_rs2),
        .in_br_kind     (in_br_kind),
        .in_ctrl        (in_ctrl),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_src1       (out_src1),
        .out_src2       (out_src2),
        .out_pc         (out_pc),
        .out_imm        (out_imm),
        .out_rd         (out_rd),
        .out_ctrl       (out_ctrl),
        .fwd_valid      (fwd_valid),
        .fwd_pending    (fwd_pending),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int unsigned idx, input logic vld, input logic pend,
                           input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
        fwd_valid[idx]                 = vld;
        fwd_pending[idx]               = pend;
        fwd_addr[idx*AW +: AW]         = addr;
        fwd_data[idx*DATA_W +: DATA_W] = data;
    endtask

    task automatic clr_fwd();
        fwd_valid   = '0;
        fwd_pending = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
    endtask

    task automatic wb(input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic drive(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] pred,
                         input logic [DATA_W-1:0] imm, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                         input logic u1, input logic u2, input logic [1:0] kind,
                         input logic [CTRL_W-1:0] ctrl);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_pred_pc = pred;
        in_imm     = imm;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_use_rs1 = u1;
        in_use_rs2 = u2;
        in_br_kind = kind;
        in_ctrl    = ctrl;
    endtask

    task automatic issue(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] pred,
                         input logic [DATA_W-1:0] imm, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                         input logic u1, input logic u2, input logic [1:0] kind,
                         input logic [CTRL_W-1:0] ctrl);
        drive(pc, pred, imm, rs1, rs2, rd, u1, u2, kind, ctrl);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        clr_fwd();
        drive('0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 2'd0, '0);
        in_valid  = 1'b0;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        tick();

        wb(5'd7, 32'h7);
        wb(5'd1, 32'h11);

        // Forwarding priority and hold under back-pressure
        issue(32'h200, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 2'd0, 16'h1234);
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h5);
        set_fwd(2, 1'b1, 1'b0, 5'd1, 32'h9);
        out_ready = 1'b0;
        #1;
        chk("fwd_out_valid", out_valid, 1);
        chk("fwd_src1_youngest", out_src1, 32'h5);
        chk("fwd_src2_x0", out_src2, 0);
        chk("fwd_out_pc", out_pc, 32'h200);
        chk("fwd_out_rd", out_rd, 3);
        chk("fwd_out_ctrl", out_ctrl, 16'h1234);
        chk("hold_in_ready", in_ready, 0);
        set_fwd(0, 1'b0, 1'b0, 5'd1, 32'h5);
        #1;
        chk("fwd_src1_next_src", out_src1, 32'h9);
        tick();
        chk("hold_out_valid", out_valid, 1);
        chk("hold_out_pc", out_pc, 32'h200);
        clr_fwd();
        out_ready = 1'b1;
        #1;
        chk("rf_src1", out_src1, 32'h11);
        chk("kind0_no_redirect", redirect_valid, 0);
        chk("fire_in_ready", in_ready, 1);
        tick();
        chk("after_fire_valid", out_valid, 0);

        // Load-use stall
        issue(32'h210, 32'h0, 32'h0, 5'd0, 5'd2, 5'd4, 1'b0, 1'b1, 2'd0, 16'h0);
        set_fwd(0, 1'b1, 1'b1, 5'd2, 32'h0);
        #1;
        chk("lu_valid_c0", out_valid, 0);
        chk("lu_in_ready", in_ready, 0);
        chk("lu_stall_c0", stall_cnt, 0);
        tick();
        chk("lu_valid_c1", out_valid, 0);
        chk("lu_stall_c1", stall_cnt, 1);
        tick();
        chk("lu_stall_c2", stall_cnt, 2);
        set_fwd(0, 1'b1, 1'b0, 5'd2, 32'h77);
        #1;
        chk("lu_issue_valid", out_valid, 1);
        chk("lu_issue_src2", out_src2, 32'h77);
        tick();
        chk("lu_after_valid", out_valid, 0);
        chk("lu_stall_final", stall_cnt, 2);
        clr_fwd();

        // Write-back bypass and x0 write suppression
        issue(32'h220, 32'h0, 32'h0, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 2'd0, 16'h0);
        wb_en   = 1'b1;
        wb_addr = 5'd4;
        wb_data = 32'hAB;
        #1;
        chk("wb_bypass_src1", out_src1, 32'hAB);
        tick();
        wb_en = 1'b0;
        issue(32'h224, 32'h0, 32'h0, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 2'd0, 16'h0);
        #1;
        chk("wb_rf_src1", out_src1, 32'hAB);
        tick();
        wb(5'd0, 32'h55);
        issue(32'h228, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 2'd0, 16'h0);
        #1;
        chk("x0_src1", out_src1, 0);
        tick();

        // beq taken but predicted fall-through: redirect, concurrent input dropped
        issue(32'h100, 32'h104, 32'h20, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 2'd1, 16'h0);
        drive(32'h300, 32'h304, 32'h0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 2'd0, 16'hBEEF);
        #1;
        chk("beq_out_valid", out_valid, 1);
        chk("beq_redirect", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("beq_pulse_end", redirect_valid, 0);
        chk("beq_drop_valid", out_valid, 0);

        issue(32'h100, 32'h104, 32'h20, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 2'd2, 16'h0);
        #1;
        chk("bne_nt_redirect", redirect_valid, 0);
        chk("bne_nt_valid", out_valid, 1);
        tick();
        issue(32'h100, 32'h104, 32'h20, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 2'd2, 16'h0);
        #1;
        chk("bne_t_redirect", redirect_valid, 1);
        chk("bne_t_pc", redirect_pc, 32'h120);
        tick();
        issue(32'h400, 32'h404, 32'h20, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 2'd3, 16'h0);
        set_fwd(1, 1'b1, 1'b0, 5'd5, 32'hFFFF_FFF0);
        #1;
        chk("jirl_redirect", redirect_valid, 1);
        chk("jirl_wrap_pc", redirect_pc, 32'h10);
        tick();
        clr_fwd();

        // Reset asserted mid-stall under back-pressure
        issue(32'h500, 32'h0, 32'h0, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 2'd1, 16'h0);
        set_fwd(0, 1'b1, 1'b1, 5'd2, 32'h0);
        out_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_stall", stall_cnt, 4);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_redirect", redirect_valid, 0);
        chk("mid_rst_out_pc", out_pc, 0);
        @(negedge clk);
        reset = 1'b0;
        clr_fwd();
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_redirect", redirect_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
